// File: rtl/conv_ctrl_pkg.sv
// Shared types and width helpers for the convolution input-side sequencer.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StWork,
        StDone
    } state_e;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned win_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned grp_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/conv_in_ctrl_gen_if.sv
// Control/address bundle between the conv input sequencer and its RAMs/datapath.
interface conv_in_ctrl_gen_if #(
    parameter int unsigned LINE_WIN = 24,
    parameter int unsigned NUM_GRP  = 1,
    parameter int unsigned DADDR_W  = 8,
    parameter int unsigned WADDR_W  = 9
);
    localparam int unsigned WIN_W = conv_ctrl_pkg::win_w(LINE_WIN);
    localparam int unsigned GRP_W = conv_ctrl_pkg::grp_w(NUM_GRP);

    logic               conv_valid_i;
    logic               stall_i;
    logic [DADDR_W-1:0] data_ram_addr_o;
    logic [WADDR_W-1:0] wt_ram_addr_o;
    logic               wt_buf_en_o;
    logic               in_buf_en_o;
    logic               in_buf_zero_o;
    logic               win_mux_zero_o;
    logic [WIN_W-1:0]   conv_win_cnt_o;
    logic [GRP_W-1:0]   grp_o;
    logic               vbit_o;
    logic               done_o;

    modport master (
        input  conv_valid_i, stall_i,
        output data_ram_addr_o, wt_ram_addr_o, wt_buf_en_o, in_buf_en_o, in_buf_zero_o,
               win_mux_zero_o, conv_win_cnt_o, grp_o, vbit_o, done_o
    );

    modport slave (
        output conv_valid_i, stall_i,
        input  data_ram_addr_o, wt_ram_addr_o, wt_buf_en_o, in_buf_en_o, in_buf_zero_o,
               win_mux_zero_o, conv_win_cnt_o, grp_o, vbit_o, done_o
    );

endinterface

// File: rtl/conv_wrap_cnt.sv
// Enable/clear counter that returns to zero after reaching a wrap value.
module conv_wrap_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] wrap_val,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    logic [W-1:0] cnt_q, cnt_d;

    assign wrap = (cnt_q == wrap_val);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_in_ctrl_gen.sv
// Conv input-side sequencer: walks line/weight RAM addresses, strobes buffers and window valid.
// Define CONV_PAD_EN to drive win_mux_zero_o for windows of line PAD_ADDR.
module conv_in_ctrl_gen
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned LINE_WIN   = 24,
    parameter int unsigned LAST_ADDR  = 51,
    parameter int unsigned INIT_LOADS = 2,
    parameter int unsigned NUM_GRP    = 1,
    parameter int unsigned PAD_ADDR   = 50,
    parameter int unsigned DADDR_W    = 8,
    parameter int unsigned WADDR_W    = 9
) (
    input logic                clk,
    input logic                rstn,
    conv_in_ctrl_gen_if.master bus
);
    localparam int unsigned WIN_W  = win_w(LINE_WIN);
    localparam int unsigned GRP_W  = grp_w(NUM_GRP);
    localparam int unsigned INIT_W = win_w(INIT_LOADS + 1);

    localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(INIT_LOADS);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(LINE_WIN - 1);
    localparam logic [WIN_W-1:0]   WIN_PEN   = WIN_W'(LINE_WIN - 2);
    localparam logic [DADDR_W-1:0] DATA_LAST = DADDR_W'(LAST_ADDR);
    localparam logic [GRP_W-1:0]   GRP_LAST  = GRP_W'(NUM_GRP - 1);

    state_e             state_q, state_d;
    logic [DADDR_W-1:0] data_addr_q, data_addr_d;
    logic [WADDR_W-1:0] wt_addr_q, wt_addr_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic               buf_en_q, buf_en_d;
    logic               first_q, first_d;
    logic [INIT_W-1:0]  init_cnt;
    logic               init_wrap;
    logic [WIN_W-1:0]   win_cnt;
    logic               win_wrap;
    logic               in_init, in_work, abort, line_done, grp_end, go_idle;

    assign in_init   = (state_q == StInit);
    assign in_work   = (state_q == StWork);
    assign abort     = (in_init | in_work) & ~bus.conv_valid_i;
    assign line_done = in_work & win_wrap & ~bus.stall_i;
    assign grp_end   = line_done & (data_addr_q == DATA_LAST);

    conv_wrap_cnt #(.W(INIT_W)) u_init_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .en       (in_init),
        .clr      (~in_init | abort),
        .wrap_val (INIT_LAST),
        .cnt      (init_cnt),
        .wrap     (init_wrap)
    );

    conv_wrap_cnt #(.W(WIN_W)) u_win_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .en       (in_work & ~bus.stall_i),
        .clr      (~in_work | abort),
        .wrap_val (WIN_LAST),
        .cnt      (win_cnt),
        .wrap     (win_wrap)
    );

    always_comb begin
        state_d     = state_q;
        data_addr_d = data_addr_q;
        wt_addr_d   = wt_addr_q;
        grp_d       = grp_q;
        buf_en_d    = 1'b0;
        first_d     = 1'b0;
        go_idle     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.conv_valid_i) state_d = StInit;
            end
            StInit: begin
                if (init_cnt == '0) begin
                    data_addr_d = '0;
                end else if (init_cnt < INIT_LAST) begin
                    data_addr_d = data_addr_q + DADDR_W'(1);
                end
                if (init_cnt < INIT_LAST) begin
                    wt_addr_d = wt_addr_q + WADDR_W'(1);
                    buf_en_d  = 1'b1;
                end
                first_d = (init_cnt == '0);
                if (init_wrap) state_d = StWork;
                go_idle = abort;
            end
            StWork: begin
                // Line address steps one window early so the next line is ready at wrap.
                if (!bus.stall_i && (win_cnt == WIN_PEN)) data_addr_d = data_addr_q + DADDR_W'(1);
                if (grp_end) begin
                    if (grp_q < GRP_LAST) begin
                        grp_d   = grp_q + GRP_W'(1);
                        state_d = StInit;
                    end else begin
                        state_d = StDone;
                    end
                end
                go_idle = abort;
            end
            StDone: begin
                go_idle = ~bus.conv_valid_i;
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
        if (go_idle) begin
            state_d     = StIdle;
            data_addr_d = '0;
            wt_addr_d   = '0;
            grp_d       = '0;
            buf_en_d    = 1'b0;
            first_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            data_addr_q <= '0;
            wt_addr_q   <= '0;
            grp_q       <= '0;
            buf_en_q    <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_addr_q <= data_addr_d;
            wt_addr_q   <= wt_addr_d;
            grp_q       <= grp_d;
            buf_en_q    <= buf_en_d;
            first_q     <= first_d;
        end
    end

    assign bus.data_ram_addr_o = data_addr_q;
    assign bus.wt_ram_addr_o   = wt_addr_q;
    assign bus.wt_buf_en_o     = buf_en_q;
    assign bus.in_buf_en_o     = buf_en_q | line_done;
    assign bus.in_buf_zero_o   = buf_en_q & first_q;
    assign bus.conv_win_cnt_o  = win_cnt;
    assign bus.grp_o           = grp_q;
    assign bus.vbit_o          = in_work & ~bus.stall_i;
    assign bus.done_o          = (state_q == StDone);

`ifdef CONV_PAD_EN
    localparam logic [DADDR_W-1:0] PAD_LINE = DADDR_W'(PAD_ADDR);
    logic pad_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pad_q <= 1'b0;
        end else begin
            pad_q <= in_work & ~abort & (data_addr_q == PAD_LINE);
        end
    end

    assign bus.win_mux_zero_o = pad_q;
`else
    logic unused_pad;
    assign unused_pad         = ^PAD_ADDR;
    assign bus.win_mux_zero_o = 1'b0;
`endif

endmodule
